// File: rtl/tf_loop_controller_if.sv
// Handshake/bus bundle between the twiddle loop controller and its neighbours.
// The slave side is the controller; the master side is the sequencer/BFU-control consumer.
interface tf_loop_controller_if;
    logic       start;
    logic [2:0] conf_in;
    logic       stall;
    logic [2:0] conf;
    logic [9:0] p;
    logic [6:0] k;
    logic       valid;
    logic       busy;
    logic       done;

    modport slave (
        input  start,
        input  conf_in,
        input  stall,
        output conf,
        output p,
        output k,
        output valid,
        output busy,
        output done
    );

    modport master (
        output start,
        output conf_in,
        output stall,
        input  conf,
        input  p,
        input  k,
        input  valid,
        input  busy,
        input  done
    );
endinterface

// File: rtl/tf_loop_controller.sv
// Walks the five radix-2 NTT/INTT stages (p = 4..0), issuing one (p, k) butterfly slot
// per unstalled cycle, with optional drain bubbles between stages.
module tf_loop_controller #(
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    tf_loop_controller_if.slave   bus
);
    localparam int unsigned STAGE_CYCLES = 128;

    // Last hold count of a group, per stage: 128/G(p) - 1.
    localparam logic [6:0] HOLD_LAST_P4 = 7'(STAGE_CYCLES - 1);
    localparam logic [6:0] HOLD_LAST_P3 = 7'(STAGE_CYCLES / 4 - 1);
    localparam logic [6:0] HOLD_LAST_P2 = 7'(STAGE_CYCLES / 16 - 1);
    localparam logic [6:0] HOLD_LAST_P1 = 7'(STAGE_CYCLES / 64 - 1);
    localparam logic [6:0] HOLD_LAST_P0 = 7'(STAGE_CYCLES / 128 - 1);
    localparam logic [7:0] GAP_LAST     = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] conf_q,  conf_d;
    logic [2:0] p_q,     p_d;
    logic [6:0] k_q,     k_d;
    logic [6:0] hold_q,  hold_d;
    logic [7:0] gap_q,   gap_d;
    logic       valid_q, valid_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    function automatic logic [6:0] grp_last(input logic [2:0] pp);
        case (pp)
            3'd4:    return 7'd0;
            3'd3:    return 7'd3;
            3'd2:    return 7'd15;
            3'd1:    return 7'd63;
            default: return 7'd127;
        endcase
    endfunction

    function automatic logic [6:0] hold_last(input logic [2:0] pp);
        case (pp)
            3'd4:    return HOLD_LAST_P4;
            3'd3:    return HOLD_LAST_P3;
            3'd2:    return HOLD_LAST_P2;
            3'd1:    return HOLD_LAST_P1;
            default: return HOLD_LAST_P0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        conf_d  = conf_q;
        p_d     = p_q;
        k_d     = k_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = S_RUN;
                    conf_d  = bus.conf_in;
                    p_d     = 3'd4;
                    k_d     = '0;
                    hold_d  = '0;
                    gap_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end

            S_RUN: begin
                // The registers hold the slot on the outputs; it is consumed only when
                // valid_q was high, so a stalled cycle re-presents the same slot.
                valid_d = !bus.stall;
                if (valid_q) begin
                    if (hold_q == hold_last(p_q)) begin
                        hold_d = '0;
                        if (k_q == grp_last(p_q)) begin
                            if (p_q == 3'd0) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                valid_d = 1'b0;
                            end else if (GAP_CYCLES != 0) begin
                                state_d = S_GAP;
                                gap_d   = '0;
                                valid_d = 1'b0;
                            end else begin
                                p_d = p_q - 3'd1;
                                k_d = '0;
                            end
                        end else begin
                            k_d = k_q + 7'd1;
                        end
                    end else begin
                        hold_d = hold_q + 7'd1;
                    end
                end
            end

            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_RUN;
                    p_d     = p_q - 3'd1;
                    k_d     = '0;
                    hold_d  = '0;
                    gap_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            conf_q  <= '0;
            p_q     <= '0;
            k_q     <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            conf_q  <= conf_d;
            p_q     <= p_d;
            k_q     <= k_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.conf  = conf_q;
    assign bus.p     = {7'd0, p_q};
    assign bus.k     = k_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
